// File: rtl/menu_scroll_ctrl_if.sv
// Signal bundle between the game logic and the menu scroller: character load
// handshake, abort/game-state controls, and the 4-digit display outputs.
interface menu_scroll_ctrl_if;
    logic [2:0]  presente;
    logic        load_valid;
    logic [6:0]  load_char;
    logic        load_last;
    logic        load_ready;
    logic        abort;
    logic [27:0] display_menu;
    logic        busy;
    logic        done;

    modport master (
        output presente, load_valid, load_char, load_last, abort,
        input  load_ready, display_menu, busy, done
    );

    modport slave (
        input  presente, load_valid, load_char, load_last, abort,
        output load_ready, display_menu, busy, done
    );
endinterface

// File: rtl/menu_scroll_ctrl.sv
// Scrolling 4-digit menu banner: characters are buffered, then shifted right-to-left
// through the display window. Define MENU_SCROLL_LOOP_EN to repeat the message until abort.
module menu_scroll_ctrl #(
    parameter logic [26:0] STEP_DIV = 27'd6750000,
    parameter int          MSG_MAX  = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    menu_scroll_ctrl_if.slave bus
);
    // state  | meaning
    // IDLE   | no message, display blank, waiting for the first character
    // LOAD   | collecting characters until one arrives with load_last
    // SCROLL | window advances one position every STEP_DIV cycles
    // PAUSE  | game left WLCM/CH; window, display and step counter frozen
    typedef enum logic [1:0] {IDLE, LOAD, SCROLL, PAUSE} state_t;

    localparam int                LEN_W    = $clog2(MSG_MAX + 1);
    localparam int                IDX_W    = $clog2(MSG_MAX);
    localparam int                W_W      = $clog2(MSG_MAX + 4);
    localparam logic [LEN_W-1:0]  LEN_MAX  = LEN_W'(MSG_MAX);
    localparam logic [26:0]       CNT_LAST = STEP_DIV - 27'd1;

    state_t             state, state_nxt;
    logic [LEN_W-1:0]   len, len_nxt;
    logic [LEN_W-1:0]   acc, acc_nxt, acc_inc;
    logic [W_W-1:0]     w, w_nxt;
    logic [26:0]        cnt, cnt_nxt;
    logic               done_q, done_nxt;
    logic [27:0]        disp, win_nxt;
    logic               wr_en;
    logic [IDX_W-1:0]   wr_idx;
    logic [6:0]         buf_q [MSG_MAX];
    logic               xfer, scroll_ok, last_window;

    assign bus.load_ready   = (state == IDLE) || (state == LOAD);
    assign bus.busy         = (state != IDLE);
    assign bus.display_menu = disp;
    assign bus.done         = done_q;

    assign xfer        = bus.load_valid && bus.load_ready;
    assign scroll_ok   = (bus.presente == 3'd1) || (bus.presente == 3'd2);
    assign last_window = (w == W_W'(len) + W_W'(3));
    // Accepted-character count saturates; extra characters are swallowed.
    assign acc_inc     = (acc == LEN_MAX) ? LEN_MAX : acc + LEN_W'(1);

    always_comb begin
        state_nxt = state;
        len_nxt   = len;
        acc_nxt   = acc;
        w_nxt     = w;
        cnt_nxt   = cnt;
        done_nxt  = 1'b0;
        wr_en     = 1'b0;
        wr_idx    = acc[IDX_W-1:0];
        if (bus.abort) begin
            state_nxt = IDLE;
            len_nxt   = '0;
            acc_nxt   = '0;
            w_nxt     = '0;
            cnt_nxt   = '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (xfer) begin
                        wr_en   = 1'b1;
                        wr_idx  = '0;
                        acc_nxt = LEN_W'(1);
                        if (bus.load_last) begin
                            state_nxt = SCROLL;
                            len_nxt   = LEN_W'(1);
                            w_nxt     = W_W'(1);
                            cnt_nxt   = '0;
                        end else begin
                            state_nxt = LOAD;
                        end
                    end
                end
                LOAD: begin
                    if (xfer) begin
                        wr_en   = (acc != LEN_MAX);
                        acc_nxt = acc_inc;
                        if (bus.load_last) begin
                            state_nxt = SCROLL;
                            len_nxt   = acc_inc;
                            w_nxt     = W_W'(1);
                            cnt_nxt   = '0;
                        end
                    end
                end
                SCROLL: begin
                    if (!scroll_ok) begin
                        state_nxt = PAUSE;
                    end else if (cnt == CNT_LAST) begin
                        cnt_nxt = '0;
                        if (last_window) begin
                            done_nxt = 1'b1;
`ifdef MENU_SCROLL_LOOP_EN
                            w_nxt = W_W'(1);
`else
                            state_nxt = IDLE;
                            w_nxt     = '0;
                            acc_nxt   = '0;
`endif
                        end else begin
                            w_nxt = w + W_W'(1);
                        end
                    end else begin
                        cnt_nxt = cnt + 27'd1;
                    end
                end
                PAUSE: begin
                    if (scroll_ok) state_nxt = SCROLL;
                end
                default: state_nxt = IDLE;
            endcase
        end
    end

    // Window for the next cycle. The slot being written this cycle is bypassed so a
    // single-character message shows up on the entry edge.
    always_comb begin
        int idx;
        idx     = 0;
        win_nxt = '0;
        for (int k = 0; k < 4; k++) begin
            idx = int'(w_nxt) + k - 4;
            if (idx >= 0 && idx < int'(len_nxt)) begin
                if (wr_en && idx == int'(wr_idx))
                    win_nxt[27 - 7*k -: 7] = bus.load_char;
                else
                    win_nxt[27 - 7*k -: 7] = buf_q[idx[IDX_W-1:0]];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            len    <= '0;
            acc    <= '0;
            w      <= '0;
            cnt    <= '0;
            done_q <= 1'b0;
            disp   <= '0;
        end else begin
            state  <= state_nxt;
            len    <= len_nxt;
            acc    <= acc_nxt;
            w      <= w_nxt;
            cnt    <= cnt_nxt;
            done_q <= done_nxt;
            if (state_nxt == SCROLL)
                disp <= win_nxt;
            else if (state_nxt != PAUSE)
                disp <= '0;
        end
    end

    // Message buffer is never cleared; the window logic masks anything beyond len.
    always_ff @(posedge clk) begin
        if (wr_en) buf_q[wr_idx] <= bus.load_char;
    end
endmodule

// File: tb/tb_menu_scroll_ctrl.sv
// Scoreboard bench for menu_scroll_ctrl: expected windows and their arrival cycles are
// queued when a message is sent and popped as the display changes.
`timescale 1ns/1ps
module tb_menu_scroll_ctrl;
    localparam int SD      = 4;
    localparam int MSG_MAX = 16;

    typedef struct {
        string       tag;
        int          at;
        logic [27:0] disp;
        logic        done;
        logic        busy;
    } exp_t;

    logic       clk   = 1'b0;
    logic       rst_n = 1'b0;
    int         cyc   = 0;
    int         n_checks = 0;
    int         n_errors = 0;
    int         t0 = 0;
    exp_t       sb[$];
    logic [6:0] msg[$];

    menu_scroll_ctrl_if bus();

    menu_scroll_ctrl #(.STEP_DIV(27'(SD)), .MSG_MAX(MSG_MAX)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic int msg_len();
        return (msg.size() > MSG_MAX) ? MSG_MAX : msg.size();
    endfunction

    function automatic logic [27:0] win(input int w, input int len);
        logic [27:0] r;
        r = '0;
        for (int k = 0; k < 4; k++)
            if (w + k - 4 >= 0 && w + k - 4 < len) r[27 - 7*k -: 7] = msg[w + k - 4];
        return r;
    endfunction

    task automatic check_idle(input string name);
        check_val({name, "_disp"},  bus.display_menu, 0);
        check_val({name, "_done"},  bus.done, 0);
        check_val({name, "_busy"},  bus.busy, 0);
        check_val({name, "_ready"}, bus.load_ready, 1);
    endtask

    // Drives msg one character per cycle; t0 becomes the cycle the first window shows.
    task automatic send_msg(input logic [2:0] pres);
        bus.presente = pres;
        for (int i = 0; i < msg.size(); i++) begin
            bus.load_valid = 1'b1;
            bus.load_char  = msg[i];
            bus.load_last  = (i == msg.size() - 1);
            check_val($sformatf("load_ready_%0d", i), bus.load_ready, 1);
            @(negedge clk);
        end
        bus.load_valid = 1'b0;
        bus.load_last  = 1'b0;
        t0 = cyc;
    endtask

    task automatic push_windows(input int w_lo, input int w_hi, input int t_lo, input bit add_done,
                                input logic [27:0] done_disp, input logic done_busy);
        exp_t e;
        for (int w = w_lo; w <= w_hi; w++) begin
            e.tag = $sformatf("w%0d", w); e.at = t_lo + (w - w_lo) * SD;
            e.disp = win(w, msg_len()); e.done = 1'b0; e.busy = 1'b1;
            sb.push_back(e);
        end
        if (add_done) begin
            e.tag = "done"; e.at = t_lo + (w_hi - w_lo + 1) * SD;
            e.disp = done_disp; e.done = 1'b1; e.busy = done_busy;
            sb.push_back(e);
        end
    endtask

    task automatic run_sb(input string name, input logic [27:0] prev_in);
        logic [27:0] prev;
        exp_t        e;
        prev = prev_in;
        while (sb.size() > 0) begin
            if (bus.display_menu !== prev || bus.done === 1'b1) begin
                e = sb.pop_front();
                check_val({name, "_", e.tag, "_cycle"}, cyc, e.at);
                check_val({name, "_", e.tag, "_disp"},  bus.display_menu, e.disp);
                check_val({name, "_", e.tag, "_done"},  bus.done, e.done);
                check_val({name, "_", e.tag, "_busy"},  bus.busy, e.busy);
                prev = bus.display_menu;
            end else if (cyc > sb[0].at) begin
                check_val({name, "_", sb[0].tag, "_timeout"}, cyc, sb[0].at);
                e = sb.pop_front();
            end
            if (sb.size() > 0) @(negedge clk);
        end
    endtask

    initial begin
        int tw2, c, bad;
        bus.presente = 3'd1; bus.load_valid = 1'b0; bus.load_char = '0;
        bus.load_last = 1'b0; bus.abort = 1'b0;
        repeat (2) @(negedge clk);
        check_idle("reset_hold");
        rst_n = 1'b1;
        @(negedge clk);
        check_idle("reset_release");

`ifdef MENU_SCROLL_LOOP_EN
        msg = '{7'h3F, 7'h06};
        send_msg(3'd1);
        push_windows(1, 5, t0, 1'b1, win(1, 2), 1'b1);
        push_windows(2, 5, t0 + 6 * SD, 1'b1, win(1, 2), 1'b1);
        run_sb("loop", 28'd0);
        @(negedge clk);
        check_val("loop_done_pulse", bus.done, 0);
        check_val("loop_busy", bus.busy, 1);
        bus.abort = 1'b1;
        @(negedge clk);
        bus.abort = 1'b0;
        check_idle("loop_abort");
`else
        // 20 characters: last four swallowed, len saturates at 16
        msg.delete();
        for (int i = 0; i < 20; i++) msg.push_back(7'(33 + i));
        send_msg(3'd1);
        push_windows(1, msg_len() + 3, t0, 1'b1, 28'd0, 1'b0);
        run_sb("long", 28'd0);
        @(negedge clk);
        check_idle("long_after");

        // short message over a buffer full of stale characters
        msg = '{7'h3F, 7'h06, 7'h5B};
        send_msg(3'd1);
        push_windows(1, 6, t0, 1'b1, 28'd0, 1'b0);
        run_sb("three", 28'd0);
        @(negedge clk);
        check_idle("three_after");

        // pause at w=2 for 10 cycles, resume on presente=2
        msg = '{7'h38, 7'h3E, 7'h6D};
        send_msg(3'd1);
        push_windows(1, 2, t0, 1'b0, 28'd0, 1'b0);
        run_sb("pause_pre", 28'd0);
        tw2 = cyc;
        @(negedge clk);
        bus.presente = 3'd3;
        c = cyc - tw2;
        bad = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (bus.display_menu !== win(2, 3) || bus.busy !== 1'b1 || bus.done !== 1'b0) bad++;
        end
        check_val("pause_frozen", bad, 0);
        check_val("pause_ready", bus.load_ready, 0);
        bus.presente = 3'd2;
        push_windows(3, 6, cyc + 1 + (SD - c), 1'b1, 28'd0, 1'b0);
        run_sb("pause_post", win(2, 3));
        @(negedge clk);
        check_idle("pause_after");

        // abort together with a load attempt mid-scroll
        msg = '{7'h77, 7'h7C, 7'h39, 7'h5E};
        send_msg(3'd1);
        push_windows(1, 2, t0, 1'b0, 28'd0, 1'b0);
        run_sb("abort_pre", 28'd0);
        @(negedge clk);
        bus.abort = 1'b1; bus.load_valid = 1'b1; bus.load_char = 7'h7F; bus.load_last = 1'b1;
        @(negedge clk);
        check_idle("abort_scroll");
        @(negedge clk);
        check_idle("abort_idle_load");
        bus.abort = 1'b0; bus.load_valid = 1'b0; bus.load_last = 1'b0;
        bad = 0;
        for (int i = 0; i < 24; i++) begin
            @(negedge clk);
            if (bus.done !== 1'b0 || bus.display_menu !== 28'd0 || bus.busy !== 1'b0) bad++;
        end
        check_val("abort_quiet", bad, 0);

        // asynchronous reset mid-scroll
        msg = '{7'h06, 7'h5B};
        send_msg(3'd2);
        push_windows(1, 2, t0, 1'b0, 28'd0, 1'b0);
        run_sb("rst_pre", 28'd0);
        #2 rst_n = 1'b0;
        #1 check_idle("rst_async");
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check_idle("rst_release");

        // single character goes straight to SCROLL; done after four windows
        msg = '{7'h76};
        send_msg(3'd2);
        push_windows(1, 4, t0, 1'b1, 28'd0, 1'b0);
        run_sb("single", 28'd0);
        check_val("single_span", cyc - t0, 4 * SD);
        @(negedge clk);
        check_idle("single_after");
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
